// File: rtl/fl_reg_port_pkg.sv
// Shared constants and types for the wide register-port responder:
// address decode fields, status word layout and the descriptor type.
package fl_reg_port_pkg;

    localparam int LINE_W        = 512;
    localparam int ADDR_DESC_BIT = 31;
    localparam int LINE_OFS      = 6;
    localparam int DESC_W_DFLT   = 128;

    localparam int ST_RX_CNT_LSB = 0;
    localparam int ST_TX_CNT_LSB = 8;
    localparam int ST_RX_EMPTY   = 16;
    localparam int ST_TX_FULL    = 17;
    localparam int ST_TX_OVF     = 18;

    typedef logic [DESC_W_DFLT-1:0] desc_t;

endpackage

// File: rtl/fl_desc_fifo.sv
// Synchronous show-ahead descriptor FIFO; the head entry is visible on data_o
// whenever the FIFO is non-empty, and data_o reads as zero while empty.
module fl_desc_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // A push into a full FIFO and a pop from an empty one are both no-ops.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end

    // NOTE: storage has no reset; emptiness is tracked by count_q alone, which
    // keeps the array mappable onto RAM resources.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fl_reg_port_responder.sv
// Responder for the core's wide register port: a 512-bit line buffer plus an
// RX descriptor FIFO (host push, core pop) and a TX FIFO (core push, host pop).
module fl_reg_port_responder
    import fl_reg_port_pkg::*;
#(
    parameter int LINES      = 64,
    parameter int DESC_W     = DESC_W_DFLT,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              reg_rd_i,
    input  logic [31:0]       reg_raddr_i,
    output logic [511:0]      reg_rdata_o,
    output logic              reg_rvalid_o,
    output logic              reg_rvalid_desp_o,
    input  logic              reg_wr_i,
    input  logic              reg_wr_desp_i,
    input  logic [31:0]       reg_waddr_i,
    input  logic [511:0]      reg_wdata_i,
    input  logic [31:0]       status_i,
    output logic [31:0]       status_o,
    input  logic              rx_desc_valid_i,
    input  logic [DESC_W-1:0] rx_desc_i,
    output logic              rx_desc_ready_o,
    output logic              tx_desc_valid_o,
    output logic [DESC_W-1:0] tx_desc_o,
    input  logic              tx_desc_ready_i,
    output logic [31:0]       core_status_o
);

    localparam int LW = $clog2(LINES);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [LINE_W-1:0] line_mem [LINES];

    logic [LW-1:0]     rd_idx, wr_idx;
    logic              rd_desc, line_we, rx_pop;
    logic              rx_full, rx_empty, tx_full, tx_empty;
    logic [CW-1:0]     rx_count, tx_count;
    logic [DESC_W-1:0] rx_head;

    logic [LINE_W-1:0] rdata_d, rdata_q;
    logic              rvalid_d, rvalid_q;
    logic              desp_d, desp_q;
    logic [31:0]       status_d, status_q;
    logic [31:0]       core_status_q;
    logic              tx_ovf_d, tx_ovf_q;

    // Only bit 31 and the line index take part in decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{reg_raddr_i, reg_waddr_i};

    assign rd_idx  = reg_raddr_i[LINE_OFS +: LW];
    assign wr_idx  = reg_waddr_i[LINE_OFS +: LW];
    assign rd_desc = reg_raddr_i[ADDR_DESC_BIT];
    assign line_we = reg_wr_i && !reg_waddr_i[ADDR_DESC_BIT];
    assign rx_pop  = reg_rd_i && rd_desc;

    fl_desc_fifo #(.WIDTH(DESC_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rx_desc_valid_i),
        .pop_i   (rx_pop),
        .data_i  (rx_desc_i),
        .data_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    fl_desc_fifo #(.WIDTH(DESC_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (reg_wr_desp_i),
        .pop_i   (tx_desc_ready_i),
        .data_i  (reg_wdata_i[DESC_W-1:0]),
        .data_o  (tx_desc_o),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    assign rx_desc_ready_o = !rx_full;
    assign tx_desc_valid_o = !tx_empty;

    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = reg_rd_i;
        desp_d   = 1'b0;
        if (reg_rd_i) begin
            if (!rd_desc) begin
                rdata_d = line_mem[rd_idx];
            end else if (!rx_empty) begin
                rdata_d = LINE_W'(rx_head);
                desp_d  = 1'b1;
            end else begin
                rdata_d = '0;
            end
        end
    end

    // Status reflects the FIFO state as it stood before this edge.
    always_comb begin
        tx_ovf_d = tx_ovf_q | (reg_wr_desp_i & tx_full);
        status_d = '0;
        status_d[ST_RX_CNT_LSB +: 8] = 8'(rx_count);
        status_d[ST_TX_CNT_LSB +: 8] = 8'(tx_count);
        status_d[ST_RX_EMPTY]        = rx_empty;
        status_d[ST_TX_FULL]         = tx_full;
        status_d[ST_TX_OVF]          = tx_ovf_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
            desp_q        <= 1'b0;
            status_q      <= '0;
            core_status_q <= '0;
            tx_ovf_q      <= 1'b0;
        end else begin
            rdata_q       <= rdata_d;
            rvalid_q      <= rvalid_d;
            desp_q        <= desp_d;
            status_q      <= status_d;
            core_status_q <= status_i;
            tx_ovf_q      <= tx_ovf_d;
        end
    end

    // A same-cycle read of the line being written captures the old contents.
    always_ff @(posedge clk_i) begin
        if (line_we) line_mem[wr_idx] <= reg_wdata_i;
    end

    assign reg_rdata_o       = rdata_q;
    assign reg_rvalid_o      = rvalid_q;
    assign reg_rvalid_desp_o = desp_q;
    assign status_o          = status_q;
    assign core_status_o     = core_status_q;

endmodule
